// File: rtl/usb_fs_pkg.sv
// Shared definitions for the USB full-speed transmit path: PID codes,
// transmit arbiter state encoding and the requester-count upper bound.
package usb_fs_pkg;

  localparam int MAX_REQ = 8;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after the start pointer, wrapping at N by compare (N need not be a
// power of two).
module usb_rr_picker
  import usb_fs_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    int c;
    logic [IW-1:0] ci;
    c      = 0;
    ci     = '0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any        = 1'b1;
        onehot[ci] = 1'b1;
        idx        = ci;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares the FS packet transmitter among NUM_REQ requesters. Grants one
// owner from IDLE, muxes its byte-pull interface while BUSY, then holds
// off the next grant for IPG_BITS bit times.
// Build option: USB_TX_ARB_FIXED_PRIO_EN gives requester 0 (handshakes)
// absolute priority; the others stay round-robin among themselves.
module usb_fs_tx_arbiter
  import usb_fs_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int IPG_BITS = 2
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  input  logic                 bit_strobe,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_pid,
  input  logic [NUM_REQ-1:0]   req_data_avail,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_data_get,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 pkt_start,
  output logic [3:0]           pid,
  output logic                 tx_data_avail,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_get,
  input  logic                 pkt_end
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state, state_nx;
  logic [IW-1:0]       rr_ptr, rr_nx, owner, owner_nx, owner_inc;
  logic [3:0]          gap_cnt, gap_nx, pid_nx, win_pid;
  logic [NUM_REQ-1:0]  grant_nx, done_nx, pick_req, rr_oh, win_oh;
  logic [IW-1:0]       rr_idx, win_idx;
  logic                pkt_start_nx, rr_any;

`ifdef USB_TX_ARB_FIXED_PRIO_EN
  assign pick_req = {req[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req = req;
`endif

  usb_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (pick_req),
    .ptr    (rr_ptr),
    .onehot (rr_oh),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  // Final winner: requester 0 overrides the round-robin pick when prioritised.
  always_comb begin
`ifdef USB_TX_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      win_oh  = NUM_REQ'(1);
      win_idx = '0;
    end else begin
      win_oh  = rr_oh;
      win_idx = rr_idx;
    end
`else
    win_oh  = rr_oh;
    win_idx = rr_idx;
`endif
  end

  // PID of the prospective winner, latched at grant time.
  always_comb begin
    win_pid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_pid = req_pid[4*i +: 4];
  end

  assign owner_inc = (owner == IW'(NUM_REQ-1)) ? '0 : owner + IW'(1);

  // Next-state and registered-output logic for IDLE -> BUSY -> GAP.
  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    done_nx      = '0;
    pkt_start_nx = 1'b0;
    pid_nx       = pid;
    rr_nx        = rr_ptr;
    owner_nx     = owner;
    gap_nx       = gap_cnt;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_nx     = win_oh;
          owner_nx     = win_idx;
          pid_nx       = win_pid;
          pkt_start_nx = 1'b1;
          state_nx     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (pkt_end) begin
          done_nx  = grant;
          grant_nx = '0;
          pid_nx   = '0;
`ifdef USB_TX_ARB_FIXED_PRIO_EN
          if (owner != '0) rr_nx = owner_inc;
`else
          rr_nx    = owner_inc;
`endif
          gap_nx   = 4'(IPG_BITS);
          state_nx = (IPG_BITS == 0) ? ARB_IDLE : ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (bit_strobe) begin
          gap_nx = gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state_nx = ARB_IDLE;
        end
      end
      default: begin
        state_nx = ARB_IDLE;
        grant_nx = '0;
        pid_nx   = '0;
        gap_nx   = '0;
      end
    endcase
  end

  // State register; reset drops any packet in flight.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      done      <= '0;
      pkt_start <= 1'b0;
      pid       <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      done      <= done_nx;
      pkt_start <= pkt_start_nx;
      pid       <= pid_nx;
      rr_ptr    <= rr_nx;
      owner     <= owner_nx;
      gap_cnt   <= gap_nx;
    end
  end

  // Byte-pull data path follows the registered grant.
  always_comb begin
    tx_data_avail = 1'b0;
    tx_data       = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        tx_data_avail = req_data_avail[i];
        tx_data       = req_data[8*i +: 8];
      end
  end

  assign req_data_get = grant & {NUM_REQ{tx_data_get}};

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Self-checking bench for usb_fs_tx_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level model.
module tb_usb_fs_tx_arbiter;

  localparam int N   = 3;
  localparam int IPG = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           bit_strobe;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_pid;
  logic [N-1:0]   req_data_avail;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_data_get;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           pkt_start;
  logic [3:0]     pid;
  logic           tx_data_avail;
  logic [7:0]     tx_data;
  logic           tx_data_get;
  logic           pkt_end;

  usb_fs_tx_arbiter #(.NUM_REQ(N), .IPG_BITS(IPG)) dut (
    .clk_48mhz      (clk),
    .reset_n        (reset_n),
    .bit_strobe     (bit_strobe),
    .req            (req),
    .req_pid        (req_pid),
    .req_data_avail (req_data_avail),
    .req_data       (req_data),
    .req_data_get   (req_data_get),
    .grant          (grant),
    .done           (done),
    .pkt_start      (pkt_start),
    .pid            (pid),
    .tx_data_avail  (tx_data_avail),
    .tx_data        (tx_data),
    .tx_data_get    (tx_data_get),
    .pkt_end        (pkt_end)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: current owner index (-1 none), bit times of gap left, rr start
  int         m_owner, m_gap, m_ptr;
  logic [N-1:0] e_grant, e_done;
  logic         e_start;
  logic [3:0]   e_pid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0;
    e_grant = '0; e_done = '0; e_start = 1'b0; e_pid = '0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_next();
    int w, c;
    e_done  = '0;
    e_start = 1'b0;
    if (m_owner >= 0) begin
      if (pkt_end) begin
        e_done[m_owner] = 1'b1;
`ifdef USB_TX_ARB_FIXED_PRIO_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
        m_owner = -1;
        e_pid   = '0;
        m_gap   = IPG;
      end
    end else if (m_gap > 0) begin
      if (bit_strobe) m_gap--;
    end else if (req != '0) begin
      w = -1;
`ifdef USB_TX_ARB_FIXED_PRIO_EN
      if (req[0]) w = 0;
`endif
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && req[c]) w = c;
      end
      m_owner = w;
      e_pid   = req_pid[4*w +: 4];
      e_start = 1'b1;
    end
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
  endtask

  task automatic cycle();
    logic       ea;
    logic [7:0] ed;
    logic [N-1:0] eg;
    model_next();
    @(posedge clk); #1;
    ea = 1'b0; ed = '0; eg = '0;
    if (m_owner >= 0) begin
      ea = req_data_avail[m_owner];
      ed = req_data[8*m_owner +: 8];
      eg[m_owner] = tx_data_get;
    end
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("pkt_start", pkt_start, e_start);
    chk("pid", pid, e_pid);
    chk("tx_data_avail", tx_data_avail, ea);
    chk("tx_data", tx_data, ed);
    chk("req_data_get", req_data_get, eg);
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == '0 && n < 20) begin
      cycle();
      n++;
    end
    if (grant == '0) chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  logic [N-1:0] exp_rr [6];

  initial begin
    reset_n = 1'b0; bit_strobe = 1'b0; req = '0; pkt_end = 1'b0;
    req_pid = 12'h3A2; req_data_avail = '0; req_data = '0; tx_data_get = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_start", pkt_start, 0);
    chk("rst_pid", pid, 0);
    chk("rst_avail", tx_data_avail, 0);
    reset_n = 1'b1;

    // req=110 from rr_ptr=0 -> requester 1, then IPG before requester 2
    req = 3'b110;
    cycle();
    chk("A_grant", grant, 3'b010);
    chk("A_pid", pid, 4'h A);
    chk("A_start", pkt_start, 1);
    cycle();
    chk("A_start_once", pkt_start, 0);
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    chk("A_done", done, 3'b010);
    repeat (3) cycle();
    chk("A_gap_hold", grant, 0);
    bit_strobe = 1'b1; cycle(); cycle(); bit_strobe = 1'b0;
    chk("A_gap_end", grant, 0);
    cycle();
    chk("A_next", grant, 3'b100);

    // data mux to owner 2
    req_data_avail = 3'b100; tx_data_get = 1'b1;
    req_data[16 +: 8] = 8'hA5; req_data[0 +: 8] = 8'h11; cycle();
    chk("D_get0", req_data_get, 3'b100);
    chk("D_byte0", tx_data, 8'hA5);
    req_data[16 +: 8] = 8'h5A; cycle();
    chk("D_byte1", tx_data, 8'h5A);
    req_data[16 +: 8] = 8'hFF; cycle();
    chk("D_byte2", tx_data, 8'hFF);
    tx_data_get = 1'b0; req_data_avail = 3'b011; cycle();
    chk("D_avail_drop", tx_data_avail, 0);
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    chk("D_done", done, 3'b100);

    // round-robin with all requests held
`ifdef USB_TX_ARB_FIXED_PRIO_EN
    exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    req = 3'b111; bit_strobe = 1'b1;
    for (int p = 0; p < 6; p++) begin
      wait_grant("rr");
      chk($sformatf("rr_order%0d", p), grant, exp_rr[p]);
      pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    end

    // spurious pkt_end in IDLE
    req = '0; repeat (3) cycle();
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    chk("S_done", done, 0);
    chk("S_grant", grant, 0);

    // owner drops req while BUSY
    req = 3'b010; cycle();
    chk("O_grant", grant, 3'b010);
    req = '0; repeat (3) cycle();
    chk("O_hold", grant, 3'b010);
    chk("O_nodone", done, 0);
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    chk("O_done", done, 3'b010);

    // requester 0 served, then all request
    req = 3'b001; wait_grant("P0");
    chk("P_first", grant, 3'b001);
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;
    req = 3'b111; wait_grant("P1");
`ifdef USB_TX_ARB_FIXED_PRIO_EN
    chk("P_second", grant, 3'b001);
`else
    chk("P_second", grant, 3'b010);
`endif
    pkt_end = 1'b1; cycle(); pkt_end = 1'b0;

    // reset while a packet is starting
    req = 3'b010; req_data_avail = 3'b111; wait_grant("R0");
    reset_n = 1'b0; #1;
    chk("R_grant", grant, 0);
    chk("R_start", pkt_start, 0);
    chk("R_done", done, 0);
    chk("R_avail", tx_data_avail, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle();
    chk("R_regrant", grant, 3'b010);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req            = N'($urandom);
      req_pid        = 12'($urandom);
      req_data       = 24'($urandom);
      req_data_avail = N'($urandom);
      tx_data_get    = 1'($urandom);
      pkt_end        = ($urandom % 6) == 0;
      bit_strobe     = ($urandom % 4) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
